// File: rtl/rect80_pkg.sv
// rtl/rect80_pkg.sv - shared constants, types and helpers for the RECTANGLE-80 key schedule
package rect80_pkg;

   localparam int unsigned ROW_W = 16;
   localparam logic [4:0] RC_INIT = 5'h01;
   localparam logic [4:0] LAST_ROUND = 5'd25;

   // Nibble i of SBOX is S(i).
   localparam logic [63:0] SBOX = 64'h24F8_D30B_97E1_AC56;

   typedef logic [4:0][ROW_W-1:0] rows_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } ks_state_e;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [4:0] rc_next(input logic [4:0] rc);
      return {rc[3:0], rc[4] ^ rc[2]};
   endfunction

endpackage

// File: rtl/rect80_key_sched_if.sv
// rtl/rect80_key_sched_if.sv - key load / round-key handshake bundle (RECT80_KS_RESTART_EN adds i_restart)
interface rect80_key_sched_if;
   logic        i_key_load;
   logic [79:0] iv_key;
   logic        i_rk_ready;
   logic [63:0] ov_roundkey;
   logic        o_rk_valid;
   logic [4:0]  ov_round;
   logic        o_busy;
   logic        o_done;
`ifdef RECT80_KS_RESTART_EN
   logic        i_restart;
`endif

   modport master (
`ifdef RECT80_KS_RESTART_EN
      output i_restart,
`endif
      output i_key_load, iv_key, i_rk_ready,
      input  ov_roundkey, o_rk_valid, ov_round, o_busy, o_done
   );

   modport slave (
`ifdef RECT80_KS_RESTART_EN
      input  i_restart,
`endif
      input  i_key_load, iv_key, i_rk_ready,
      output ov_roundkey, o_rk_valid, ov_round, o_busy, o_done
   );
endinterface

// File: rtl/rect80_key_update.sv
// rtl/rect80_key_update.sv - one combinational key-schedule step: S-box columns, row Feistel, rc XOR
module rect80_key_update
   import rect80_pkg::*;
(
   input  rows_t      rows_i,
   input  logic [4:0] rc_i,
   output rows_t      rows_o
);

   rows_t      s;
   logic [3:0] nib;

   always_comb begin
      s   = rows_i;
      nib = '0;
      // Column j is the nibble {row3[j],row2[j],row1[j],row0[j]}; only the low four columns are substituted.
      for (int j = 0; j < 4; j++) begin
         nib      = sbox({rows_i[3][j], rows_i[2][j], rows_i[1][j], rows_i[0][j]});
         s[0][j]  = nib[0];
         s[1][j]  = nib[1];
         s[2][j]  = nib[2];
         s[3][j]  = nib[3];
      end

      rows_o    = s;
      rows_o[0] = {s[0][7:0], s[0][15:8]} ^ s[1];
      rows_o[1] = s[2];
      rows_o[2] = s[3];
      rows_o[3] = {s[3][3:0], s[3][15:4]} ^ s[4];
      rows_o[4] = s[0];
      rows_o[0][4:0] = rows_o[0][4:0] ^ rc_i;
   end

endmodule

// File: rtl/rect80_key_sched.sv
// rtl/rect80_key_sched.sv - RECTANGLE-80 round-key generator K0..K25 (RECT80_KS_RESTART_EN: shadow-key restart)
module rect80_key_sched
   import rect80_pkg::*;
(
   input logic               i_clk,
   input logic               i_rst_n,
   rect80_key_sched_if.slave ks
);

   ks_state_e  state_q, state_d;
   rows_t      rows_q, rows_d, rows_upd;
   logic [4:0] rc_q, rc_d;
   logic [4:0] round_q, round_d;
   logic       hs;
`ifdef RECT80_KS_RESTART_EN
   rows_t      shadow_q, shadow_d;
`endif

   rect80_key_update u_update (
      .rows_i (rows_q),
      .rc_i   (rc_q),
      .rows_o (rows_upd)
   );

   assign hs = (state_q == ST_RUN) && ks.i_rk_ready;

   // A load (or restart) overrides any handshake presented in the same cycle.
   always_comb begin
      state_d  = state_q;
      rows_d   = rows_q;
      rc_d     = rc_q;
      round_d  = round_q;
`ifdef RECT80_KS_RESTART_EN
      shadow_d = shadow_q;
`endif
      if (ks.i_key_load) begin
         state_d  = ST_RUN;
         rows_d   = ks.iv_key;
         rc_d     = RC_INIT;
         round_d  = '0;
`ifdef RECT80_KS_RESTART_EN
         shadow_d = ks.iv_key;
      end else if (ks.i_restart) begin
         state_d  = ST_RUN;
         rows_d   = shadow_q;
         rc_d     = RC_INIT;
         round_d  = '0;
`endif
      end else if (hs) begin
         if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
         end else begin
            rows_d  = rows_upd;
            rc_d    = rc_next(rc_q);
            round_d = round_q + 5'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         rows_q   <= '0;
         rc_q     <= RC_INIT;
         round_q  <= '0;
`ifdef RECT80_KS_RESTART_EN
         shadow_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rows_q   <= rows_d;
         rc_q     <= rc_d;
         round_q  <= round_d;
`ifdef RECT80_KS_RESTART_EN
         shadow_q <= shadow_d;
`endif
      end
   end

   assign ks.ov_roundkey = rows_q[3:0];
   assign ks.ov_round    = round_q;
   assign ks.o_rk_valid  = (state_q == ST_RUN);
   assign ks.o_busy      = (state_q == ST_RUN);
   assign ks.o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rect80_key_sched.sv
// tb/tb_rect80_key_sched.sv - scoreboard bench for rect80_key_sched (RECT80_KS_RESTART_EN adds restart test)
module tb_rect80_key_sched;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rect80_key_sched_if ks ();

   rect80_key_sched dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .ks      (ks)
   );

   typedef struct packed {
      logic [4:0]  rnd;
      logic [63:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic [3:0] sb [0:15] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                             4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
   logic [4:0] rc_tab [0:24] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C,
                                 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11,
                                 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D};

   function automatic logic [79:0] model_update(input logic [79:0] k, input logic [4:0] rc);
      logic [15:0] r [0:4];
      logic [15:0] t0, t3;
      logic [3:0]  n;
      for (int i = 0; i < 5; i++) r[i] = k[16*i +: 16];
      for (int j = 0; j < 4; j++) begin
         n = sb[{r[3][j], r[2][j], r[1][j], r[0][j]}];
         r[0][j] = n[0];
         r[1][j] = n[1];
         r[2][j] = n[2];
         r[3][j] = n[3];
      end
      t0 = ((r[0] << 8) | (r[0] >> 8)) ^ r[1] ^ {11'b0, rc};
      t3 = ((r[3] << 12) | (r[3] >> 4)) ^ r[4];
      return {r[0], t3, r[3], r[2], t0};
   endfunction

   task automatic push_schedule(input logic [79:0] k);
      logic [79:0] s;
      exp_q.delete();
      s = k;
      for (int n = 0; n < 26; n++) begin
         exp_q.push_back('{rnd: n[4:0], key: s[63:0]});
         if (n < 25) s = model_update(s, rc_tab[n]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ks.i_rk_ready = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({ks.ov_roundkey, ks.ov_round} !== 69'h0) begin
         fails++;
         $display("FAIL reset_key_round got %h/%0d want 0/0", ks.ov_roundkey, ks.ov_round);
      end
      tests++;
      if ({ks.o_rk_valid, ks.o_busy, ks.o_done} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags got v%b b%b d%b want 000", ks.o_rk_valid, ks.o_busy, ks.o_done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (ks.o_rk_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_ready_ignored valid got %b want 0", ks.o_rk_valid);
      end
      ks.i_rk_ready = 1'b0;
   endtask

   task automatic test_zero_key();
      @(negedge clk);
      ks.iv_key = '0;
      ks.i_key_load = 1'b1;
      push_schedule(80'h0);
      @(negedge clk);
      ks.i_key_load = 1'b0;
      tests++;
      if ({ks.o_rk_valid, ks.ov_round, ks.ov_roundkey} !== {1'b1, 5'd0, 64'h0}) begin
         fails++;
         $display("FAIL zero_k0 got v%b r%0d %h want v1 r0 0", ks.o_rk_valid, ks.ov_round, ks.ov_roundkey);
      end
      ks.i_rk_ready = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
      ks.i_rk_ready = 1'b0;
      tests++;
      if ({ks.ov_round, ks.ov_roundkey} !== {5'd1, 64'h0000_0000_000F_000E}) begin
         fails++;
         $display("FAIL zero_k1 got r%0d %h want r1 00000000000f000e", ks.ov_round, ks.ov_roundkey);
      end
      tests++;
      if (ks.ov_roundkey !== exp_q[0].key) begin
         fails++;
         $display("FAIL zero_k1_model got %h want %h", ks.ov_roundkey, exp_q[0].key);
      end
   endtask

   task automatic test_ready_high();
      logic [95:0] r;
      int nvalid;
      bit fin;
      r = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      ks.iv_key = r[79:0];
      ks.i_key_load = 1'b1;
      ks.i_rk_ready = 1'b1;
      push_schedule(r[79:0]);
      nvalid = 0;
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         ks.i_key_load = 1'b0;
         if (ks.o_rk_valid) begin
            nvalid++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL ready_high_extra got r%0d %h want no key", ks.ov_round, ks.ov_roundkey);
            end else begin
               if ({ks.ov_round, ks.ov_roundkey} !== {exp_q[0].rnd, exp_q[0].key}) begin
                  fails++;
                  $display("FAIL ready_high_key got r%0d %h want r%0d %h",
                           ks.ov_round, ks.ov_roundkey, exp_q[0].rnd, exp_q[0].key);
               end
               void'(exp_q.pop_front());
            end
         end else begin
            fin = 1'b1;
         end
      end
      tests++;
      if (nvalid != 26) begin
         fails++;
         $display("FAIL ready_high_count got %0d want 26", nvalid);
      end
      tests++;
      if ({ks.o_done, ks.o_busy, ks.o_rk_valid} !== 3'b100) begin
         fails++;
         $display("FAIL ready_high_done got d%b b%b v%b want 100", ks.o_done, ks.o_busy, ks.o_rk_valid);
      end
      ks.i_rk_ready = 1'b0;
   endtask

   task automatic test_ready_toggle();
      logic [95:0] r;
      bit fin;
      r = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      ks.iv_key = r[79:0];
      ks.i_key_load = 1'b1;
      ks.i_rk_ready = 1'b0;
      push_schedule(r[79:0]);
      fin = 1'b0;
      for (int c = 0; c < 70 && !fin; c++) begin
         @(negedge clk);
         ks.i_key_load = 1'b0;
         if (!ks.o_rk_valid) begin
            fin = 1'b1;
         end else begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL toggle_extra got r%0d %h want no key", ks.ov_round, ks.ov_roundkey);
            end else if ({ks.ov_round, ks.ov_roundkey} !== {exp_q[0].rnd, exp_q[0].key}) begin
               fails++;
               $display("FAIL toggle_key got r%0d %h want r%0d %h",
                        ks.ov_round, ks.ov_roundkey, exp_q[0].rnd, exp_q[0].key);
            end
            ks.i_rk_ready = (c % 2 == 0);
            if (ks.i_rk_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      tests++;
      if (exp_q.size() != 0 || ks.o_done !== 1'b1) begin
         fails++;
         $display("FAIL toggle_done got left=%0d done=%b want left=0 done=1", exp_q.size(), ks.o_done);
      end
      ks.i_rk_ready = 1'b0;
   endtask

   task automatic test_load_midway();
      logic [95:0] a, b;
      bit hit;
      a = {$urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      ks.iv_key = a[79:0];
      ks.i_key_load = 1'b1;
      ks.i_rk_ready = 1'b1;
      push_schedule(a[79:0]);
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         ks.i_key_load = 1'b0;
         if (ks.o_rk_valid && exp_q.size() != 0) begin
            tests++;
            if ({ks.ov_round, ks.ov_roundkey} !== {exp_q[0].rnd, exp_q[0].key}) begin
               fails++;
               $display("FAIL midway_old_key got r%0d %h want r%0d %h",
                        ks.ov_round, ks.ov_roundkey, exp_q[0].rnd, exp_q[0].key);
            end
            void'(exp_q.pop_front());
         end
         if (ks.ov_round == 5'd10) begin
            hit = 1'b1;
            ks.iv_key = b[79:0];
            ks.i_key_load = 1'b1;
            push_schedule(b[79:0]);
         end
      end
      @(negedge clk);
      ks.i_key_load = 1'b0;
      ks.i_rk_ready = 1'b0;
      tests++;
      if (!hit || {ks.o_rk_valid, ks.ov_round, ks.ov_roundkey} !== {1'b1, 5'd0, exp_q[0].key}) begin
         fails++;
         $display("FAIL midway_reload got hit%b v%b r%0d %h want v1 r0 %h",
                  hit, ks.o_rk_valid, ks.ov_round, ks.ov_roundkey, exp_q[0].key);
      end
   endtask

   task automatic test_reset_midway();
      logic [95:0] a;
      bit hit;
      a = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      ks.iv_key = a[79:0];
      ks.i_key_load = 1'b1;
      ks.i_rk_ready = 1'b1;
      push_schedule(a[79:0]);
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         ks.i_key_load = 1'b0;
         if (ks.ov_round == 5'd7) begin
            hit = 1'b1;
            rst_n = 1'b0;
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if (!hit || {ks.ov_roundkey, ks.ov_round, ks.o_rk_valid, ks.o_busy, ks.o_done} !== 72'h0) begin
         fails++;
         $display("FAIL rst_midway got hit%b %h r%0d v%b b%b d%b want all 0",
                  hit, ks.ov_roundkey, ks.ov_round, ks.o_rk_valid, ks.o_busy, ks.o_done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if ({ks.o_rk_valid, ks.ov_round, ks.o_done} !== 7'h0) begin
            fails++;
            $display("FAIL rst_ready_ignored got v%b r%0d d%b want 0", ks.o_rk_valid, ks.ov_round, ks.o_done);
         end
      end
      ks.i_rk_ready = 1'b0;
      exp_q.delete();
   endtask

`ifdef RECT80_KS_RESTART_EN
   task automatic test_restart();
      logic [95:0] a, d;
      bit fin;
      a = {$urandom(), $urandom(), $urandom()};
      d = {$urandom(), $urandom(), $urandom()};
      @(negedge clk);
      ks.iv_key = a[79:0];
      ks.i_key_load = 1'b1;
      ks.i_rk_ready = 1'b1;
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         ks.i_key_load = 1'b0;
         ks.iv_key = d[79:0];
         fin = ks.o_done;
      end
      ks.i_rk_ready = 1'b0;
      ks.i_restart = 1'b1;
      push_schedule(a[79:0]);
      @(negedge clk);
      ks.i_restart = 1'b0;
      tests++;
      if (!fin || {ks.o_rk_valid, ks.ov_round, ks.ov_roundkey} !== {1'b1, 5'd0, exp_q[0].key}) begin
         fails++;
         $display("FAIL restart_k0 got done%b v%b r%0d %h want v1 r0 %h",
                  fin, ks.o_rk_valid, ks.ov_round, ks.ov_roundkey, exp_q[0].key);
      end
      ks.i_restart = 1'b1;
      ks.i_key_load = 1'b1;
      push_schedule(d[79:0]);
      @(negedge clk);
      ks.i_restart = 1'b0;
      ks.i_key_load = 1'b0;
      tests++;
      if ({ks.ov_round, ks.ov_roundkey} !== {5'd0, exp_q[0].key}) begin
         fails++;
         $display("FAIL restart_load_priority got r%0d %h want r0 %h", ks.ov_round, ks.ov_roundkey, exp_q[0].key);
      end
   endtask
`endif

   initial begin
      ks.i_key_load = 1'b0;
      ks.iv_key     = '0;
      ks.i_rk_ready = 1'b0;
`ifdef RECT80_KS_RESTART_EN
      ks.i_restart  = 1'b0;
`endif
      test_reset();
      test_zero_key();
      test_ready_high();
      test_ready_toggle();
      test_load_midway();
      test_reset_midway();
`ifdef RECT80_KS_RESTART_EN
      test_restart();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
